// File: rtl/noc_input_port.sv
// ---------------------------------------------------------------------------
// noc_input_port
// Router input port. Incoming flits are stored in a small FIFO. The head flit
// of each packet is XY-routed. The port then holds a one-hot request to the
// chosen output arbiter until the tail flit has left. Flits are forwarded
// while the arbiter's grant stays high.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous, active-high reset
//   in_flit    incoming flit: [7:6] type, [5:4] dst_x, [3:2] dst_y, [1:0] payload
//   in_valid   in_flit valid
//   in_ready   FIFO can accept a flit this cycle (registered !full)
//   req        one-hot output request: [0]=local [1]=N [2]=E [3]=S [4]=W
//   gnt        grant from the arbiter of the requested output
//   out_flit   flit forwarded to the crossbar (holds its last value)
//   out_valid  out_flit valid, one cycle per popped flit
//   drop_err   one-cycle pulse when a non-head flit is discarded in IDLE
// ---------------------------------------------------------------------------
module noc_input_port #(
    parameter logic [1:0] MY_X  = 2'd1,
    parameter logic [1:0] MY_Y  = 2'd1,
    parameter int         DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_flit,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [4:0] req,
    input  logic       gnt,
    output logic [7:0] out_flit,
    output logic       out_valid,
    output logic       drop_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SEND = 2'd2
    } state_t;

    // ---------------- FIFO ----------------
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_in_ready;

    logic [7:0]    w_head;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_count_nxt;

    state_t        r_state;
    logic [4:0]    r_req;
    logic [7:0]    r_out_flit;
    logic          r_out_valid;
    logic          r_drop_err;
    logic [4:0]    w_route;

    assign w_head      = r_mem[r_rptr];
    assign w_empty     = (r_count == '0);
    assign w_push      = in_valid && r_in_ready;
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

    // Memory contents need no reset: the occupancy count alone decides validity.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= in_flit;
    end

    // in_ready is registered from the next occupancy. As a result, a pop in the
    // same cycle as a full FIFO does not open a push slot until the next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_in_ready <= 1'b1;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count    <= w_count_nxt;
            r_in_ready <= (w_count_nxt != CW'(DEPTH));
        end
    end

    // ---------------- XY route of the current head ----------------
    always_comb begin
        w_route = 5'b00001;                         // local
        if      (w_head[5:4] > MY_X) w_route = 5'b00100;  // E
        else if (w_head[5:4] < MY_X) w_route = 5'b10000;  // W
        else if (w_head[3:2] > MY_Y) w_route = 5'b00010;  // N
        else if (w_head[3:2] < MY_Y) w_route = 5'b01000;  // S
    end

    // Pop decision. REQ and SEND pop on the same condition. A grant seen in REQ
    // therefore starts streaming on that edge, without first moving to SEND.
    always_comb begin
        w_pop = 1'b0;
        case (r_state)
            IDLE:      w_pop = !w_empty && !w_head[6];
            REQ, SEND: w_pop = gnt && !w_empty;
            default:   w_pop = 1'b0;
        endcase
    end

    // ---------------- FSM with registered outputs ----------------
    // r_req acts as the latched route: it is loaded from the head on the
    // IDLE->REQ transition. It is cleared on the tail pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_req       <= '0;
            r_out_flit  <= '0;
            r_out_valid <= 1'b0;
            r_drop_err  <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_drop_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        if (w_head[6]) begin
                            r_req   <= w_route;
                            r_state <= REQ;
                        end else begin
                            r_drop_err <= 1'b1;
                        end
                    end
                end
                REQ, SEND: begin
                    if (!gnt) begin
                        r_state <= REQ;
                    end else if (w_empty) begin
                        r_state <= SEND;
                    end else begin
                        r_out_flit  <= w_head;
                        r_out_valid <= 1'b1;
                        if (w_head[7]) begin
                            r_req   <= '0;
                            r_state <= IDLE;
                        end else begin
                            r_state <= SEND;
                        end
                    end
                end
                default: begin
                    r_req   <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign req       = r_req;
    assign out_flit  = r_out_flit;
    assign out_valid = r_out_valid;
    assign drop_err  = r_drop_err;

endmodule

// File: tb/tb_noc_input_port.sv
// ---------------------------------------------------------------------------
// tb_noc_input_port
// Directed bench for noc_input_port (MY_X=1, MY_Y=1, DEPTH=4). Each vector
// gives the inputs for one clock edge and the outputs expected after that
// edge. Outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_noc_input_port;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_flit = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [4:0] req;
    logic       gnt = 1'b0;
    logic [7:0] out_flit;
    logic       out_valid;
    logic       drop_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    noc_input_port #(.MY_X(2'd1), .MY_Y(2'd1), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_flit   (in_flit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .req       (req),
        .gnt       (gnt),
        .out_flit  (out_flit),
        .out_valid (out_valid),
        .drop_err  (drop_err)
    );

    typedef struct {
        logic       rst;
        logic [7:0] flit;
        logic       v;
        logic       gnt;
        logic       e_rdy;
        logic [4:0] e_req;
        logic       e_ov;
        logic       e_drop;
        logic       chk_flit;
        logic [7:0] e_flit;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic [7:0] f, input logic v,
                                input logic g, input logic rdy, input logic [4:0] rq,
                                input logic ov, input logic dr, input logic cf,
                                input logic [7:0] ef);
        vec_t t;
        t.rst = r; t.flit = f; t.v = v; t.gnt = g; t.e_rdy = rdy; t.e_req = rq;
        t.e_ov = ov; t.e_drop = dr; t.chk_flit = cf; t.e_flit = ef;
        return t;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run(input vec_t t, input string tag);
        rst      = t.rst;
        in_flit  = t.flit;
        in_valid = t.v;
        gnt      = t.gnt;
        @(posedge clk);
        #1;
        chk({tag, ".in_ready"},  {7'd0, in_ready},  {7'd0, t.e_rdy});
        chk({tag, ".req"},       {3'd0, req},       {3'd0, t.e_req});
        chk({tag, ".out_valid"}, {7'd0, out_valid}, {7'd0, t.e_ov});
        chk({tag, ".drop_err"},  {7'd0, drop_err},  {7'd0, t.e_drop});
        if (t.chk_flit)
            chk({tag, ".out_flit"}, out_flit, t.e_flit);
    endtask

    vec_t tbl[17];

    initial begin
        // reset, single flit, 4-flit packet to W, dropped body then local head
        tbl[0]  = mk(1, 8'h00, 0, 0, 1, 5'b00000, 0, 0, 1, 8'h00);
        tbl[1]  = mk(0, 8'hF1, 1, 0, 1, 5'b00000, 0, 0, 0, 8'h00);
        tbl[2]  = mk(0, 8'h00, 0, 0, 1, 5'b00100, 0, 0, 0, 8'h00);
        tbl[3]  = mk(0, 8'h00, 0, 1, 1, 5'b00000, 1, 0, 1, 8'hF1);
        tbl[4]  = mk(0, 8'h00, 0, 0, 1, 5'b00000, 0, 0, 0, 8'h00);
        tbl[5]  = mk(0, 8'h40, 1, 0, 1, 5'b00000, 0, 0, 0, 8'h00);
        tbl[6]  = mk(0, 8'h01, 1, 0, 1, 5'b10000, 0, 0, 0, 8'h00);
        tbl[7]  = mk(0, 8'h02, 1, 1, 1, 5'b10000, 1, 0, 1, 8'h40);
        tbl[8]  = mk(0, 8'h80, 1, 1, 1, 5'b10000, 1, 0, 1, 8'h01);
        tbl[9]  = mk(0, 8'h00, 0, 1, 1, 5'b10000, 1, 0, 1, 8'h02);
        tbl[10] = mk(0, 8'h00, 0, 1, 1, 5'b00000, 1, 0, 1, 8'h80);
        tbl[11] = mk(0, 8'h00, 0, 0, 1, 5'b00000, 0, 0, 0, 8'h00);
        tbl[12] = mk(0, 8'h05, 1, 0, 1, 5'b00000, 0, 0, 0, 8'h00);
        tbl[13] = mk(0, 8'hD4, 1, 0, 1, 5'b00000, 0, 1, 0, 8'h00);
        tbl[14] = mk(0, 8'h00, 0, 0, 1, 5'b00001, 0, 0, 0, 8'h00);
        tbl[15] = mk(0, 8'h00, 0, 1, 1, 5'b00000, 1, 0, 1, 8'hD4);
        tbl[16] = mk(0, 8'h00, 0, 0, 1, 5'b00000, 0, 0, 0, 8'h00);

        for (int i = 0; i < 17; i++)
            run(tbl[i], $sformatf("vec%0d", i));

        // Fill to full with gnt low; the 5th flit (A0) must be refused.
        run(mk(0, 8'h70, 1, 0, 1, 5'b00000, 0, 0, 0, 8'h00), "full0");
        run(mk(0, 8'h11, 1, 0, 1, 5'b00100, 0, 0, 0, 8'h00), "full1");
        run(mk(0, 8'h12, 1, 0, 1, 5'b00100, 0, 0, 0, 8'h00), "full2");
        run(mk(0, 8'h13, 1, 0, 0, 5'b00100, 0, 0, 0, 8'h00), "full3");
        run(mk(0, 8'hA0, 1, 0, 0, 5'b00100, 0, 0, 0, 8'h00), "full4");
        run(mk(0, 8'h00, 0, 0, 0, 5'b00100, 0, 0, 0, 8'h00), "full5");
        run(mk(0, 8'h00, 0, 1, 1, 5'b00100, 1, 0, 1, 8'h70), "full6");
        run(mk(0, 8'h00, 0, 1, 1, 5'b00100, 1, 0, 1, 8'h11), "full7");
        run(mk(0, 8'h00, 0, 1, 1, 5'b00100, 1, 0, 1, 8'h12), "full8");
        run(mk(0, 8'h00, 0, 1, 1, 5'b00100, 1, 0, 1, 8'h13), "full9");
        // empty while granted: stall, and the refused A0 is not in the FIFO
        run(mk(0, 8'hA0, 1, 1, 1, 5'b00100, 0, 0, 0, 8'h00), "full10");
        run(mk(0, 8'h00, 0, 1, 1, 5'b00000, 1, 0, 1, 8'hA0), "full11");
        run(mk(0, 8'h00, 0, 0, 1, 5'b00000, 0, 0, 0, 8'h00), "full12");

        // Grant drops for two cycles mid-packet (route N).
        run(mk(0, 8'h58, 1, 0, 1, 5'b00000, 0, 0, 0, 8'h00), "gd0");
        run(mk(0, 8'h21, 1, 0, 1, 5'b00010, 0, 0, 0, 8'h00), "gd1");
        run(mk(0, 8'h22, 1, 0, 1, 5'b00010, 0, 0, 0, 8'h00), "gd2");
        run(mk(0, 8'h83, 1, 0, 0, 5'b00010, 0, 0, 0, 8'h00), "gd3");
        run(mk(0, 8'h00, 0, 1, 1, 5'b00010, 1, 0, 1, 8'h58), "gd4");
        run(mk(0, 8'h00, 0, 1, 1, 5'b00010, 1, 0, 1, 8'h21), "gd5");
        run(mk(0, 8'h00, 0, 0, 1, 5'b00010, 0, 0, 0, 8'h00), "gd6");
        run(mk(0, 8'h00, 0, 0, 1, 5'b00010, 0, 0, 0, 8'h00), "gd7");
        run(mk(0, 8'h00, 0, 1, 1, 5'b00010, 1, 0, 1, 8'h22), "gd8");
        run(mk(0, 8'h00, 0, 1, 1, 5'b00000, 1, 0, 1, 8'h83), "gd9");
        run(mk(0, 8'h00, 0, 0, 1, 5'b00000, 0, 0, 0, 8'h00), "gd10");

        // Reset during SEND with 32,33 still buffered. Leftover bodies would
        // show up as drop_err pulses after the reset is released.
        run(mk(0, 8'h60, 1, 0, 1, 5'b00000, 0, 0, 0, 8'h00), "rs0");
        run(mk(0, 8'h31, 1, 0, 1, 5'b00100, 0, 0, 0, 8'h00), "rs1");
        run(mk(0, 8'h32, 1, 0, 1, 5'b00100, 0, 0, 0, 8'h00), "rs2");
        run(mk(0, 8'h33, 1, 0, 0, 5'b00100, 0, 0, 0, 8'h00), "rs3");
        run(mk(0, 8'h00, 0, 1, 1, 5'b00100, 1, 0, 1, 8'h60), "rs4");
        run(mk(0, 8'h00, 0, 1, 1, 5'b00100, 1, 0, 1, 8'h31), "rs5");
        run(mk(1, 8'h00, 0, 1, 1, 5'b00000, 0, 0, 1, 8'h00), "rs6");
        run(mk(0, 8'h00, 0, 0, 1, 5'b00000, 0, 0, 0, 8'h00), "rs7");
        run(mk(0, 8'h00, 0, 0, 1, 5'b00000, 0, 0, 0, 8'h00), "rs8");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
